// File: rtl/out_arbiter_if.sv
// Handshake bundle between the requesters/downstream stage and out_arbiter.
// With OUT_ARB_STALL_CNT_EN defined the bundle also carries the 16-bit stall_cnt.
interface out_arbiter_if #(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = 8,
  parameter int DELAY_W = 2
);
  localparam int ID_W = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ*DATA_W-1:0] req_data;
  logic [NUM_REQ-1:0]        req_ready;
  logic [DELAY_W-1:0]        cfg_delay;
  logic [DATA_W-1:0]         out_data;
  logic                      out_valid;
  logic                      out_ready;
  logic [ID_W-1:0]           grant_id;
  logic                      busy;
`ifdef OUT_ARB_STALL_CNT_EN
  logic [15:0]               stall_cnt;
`endif

  // Arbiter side.
  modport slave (
    input  req_valid, req_data, cfg_delay, out_ready,
    output req_ready, out_data, out_valid, grant_id, busy
`ifdef OUT_ARB_STALL_CNT_EN
    , output stall_cnt
`endif
  );

  // Requester / downstream side.
  modport master (
    output req_valid, req_data, cfg_delay, out_ready,
    input  req_ready, out_data, out_valid, grant_id, busy
`ifdef OUT_ARB_STALL_CNT_EN
    , input stall_cnt
`endif
  );
endinterface

// File: rtl/out_arbiter.sv
// Round-robin arbiter feeding one output stage: accept, programmable gap, then present.
// Optional macro OUT_ARB_STALL_CNT_EN adds a saturating 16-bit backpressure stall counter.
module out_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = 8,
  parameter int DELAY_W = 2
) (
  input  logic        clk,
  input  logic        rst,
  out_arbiter_if.slave bus
);
  localparam int ID_W = $clog2(NUM_REQ);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_SEND = 2'd2;

  logic [1:0]         r_state;
  logic [DELAY_W-1:0] r_dly_cnt;
  logic [ID_W-1:0]    r_last_ptr;
  logic [ID_W-1:0]    r_grant_id;
  logic [DATA_W-1:0]  r_out_data;
  logic               r_out_valid;

  logic [2*NUM_REQ-1:0] w_dbl;
  logic [2*NUM_REQ-1:0] w_shift;
  logic [NUM_REQ-1:0]   w_rot;
  logic                 w_found;
  logic [ID_W-1:0]      w_winner;
  logic                 w_accept;
  int                   w_base;
  int                   w_sum;

  // Rotate the request vector so bit 0 is the requester after last_ptr,
  // then the lowest set bit is the round-robin winner.
  assign w_dbl   = {bus.req_valid, bus.req_valid};
  assign w_shift = w_dbl >> w_base;
  assign w_rot   = w_shift[NUM_REQ-1:0];

  always_comb begin
    w_base = int'(r_last_ptr) + 1;
    if (w_base >= NUM_REQ) begin
      w_base = 0;
    end
  end

  always_comb begin
    w_found  = 1'b0;
    w_winner = '0;
    w_sum    = 0;
    for (int o = 0; o < NUM_REQ; o++) begin
      if (!w_found && w_rot[o]) begin
        w_found = 1'b1;
        w_sum   = w_base + o;
        if (w_sum >= NUM_REQ) begin
          w_sum = w_sum - NUM_REQ;
        end
        w_winner = ID_W'(w_sum);
      end
    end
  end

  assign w_accept = (r_state == S_IDLE) && w_found && !rst;

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_ready
    assign bus.req_ready[gi] = w_accept && (w_winner == ID_W'(gi));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_dly_cnt   <= '0;
      r_last_ptr  <= ID_W'(NUM_REQ - 1);
      r_grant_id  <= '0;
      r_out_data  <= '0;
      r_out_valid <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_found) begin
            r_out_data <= bus.req_data[w_winner*DATA_W +: DATA_W];
            r_grant_id <= w_winner;
            r_dly_cnt  <= bus.cfg_delay;
            if (bus.cfg_delay != '0) begin
              r_state <= S_WAIT;
            end else begin
              r_state     <= S_SEND;
              r_out_valid <= 1'b1;
            end
          end
        end
        S_WAIT: begin
          r_dly_cnt <= r_dly_cnt - DELAY_W'(1);
          if (r_dly_cnt == DELAY_W'(1)) begin
            r_state     <= S_SEND;
            r_out_valid <= 1'b1;
          end
        end
        S_SEND: begin
          if (bus.out_ready) begin
            r_last_ptr  <= r_grant_id;
            r_out_valid <= 1'b0;
            r_state     <= S_IDLE;
          end
        end
        default: begin
          r_state     <= S_IDLE;
          r_out_valid <= 1'b0;
        end
      endcase
    end
  end

  assign bus.out_data  = r_out_data;
  assign bus.out_valid = r_out_valid;
  assign bus.grant_id  = r_grant_id;
  assign bus.busy      = (r_state != S_IDLE);

`ifdef OUT_ARB_STALL_CNT_EN
  logic [15:0] r_stall_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_stall_cnt <= '0;
    end else if (r_state == S_SEND && !bus.out_ready && r_stall_cnt != 16'hFFFF) begin
      r_stall_cnt <= r_stall_cnt + 16'd1;
    end
  end

  assign bus.stall_cnt = r_stall_cnt;
`endif

endmodule

// File: doc/out_arbiter.md
# out_arbiter

Round-robin arbiter and sequencer that shares the single 8-bit output processing stage between several upstream requesters. It accepts one beat at a time from the winning requester over a valid/ready handshake and inserts a programmable inter-beat gap. It then presents the beat downstream with a stable valid/ready handshake. It sits between the per-channel producers and the output stage, replacing direct fixed-delay hookup of a single source.

## Interface
- NUM_REQ, 4: number of requesters, 2..8.
- DATA_W, 8: beat width.
- DELAY_W, 2: width of the gap-length configuration.
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  NUM_REQ  per-requester beat valid.
- req_data  in  NUM_REQ*DATA_W  requester i occupies bits [i*DATA_W +: DATA_W].
- req_ready  out  NUM_REQ  one-hot accept strobe; a beat transfers when req_valid[i] && req_ready[i].
- cfg_delay  in  DELAY_W  gap cycles inserted between accept and presentation.
- out_data  out  DATA_W  granted beat.
- out_valid  out  1  out_data valid.
- out_ready  in  1  downstream accept.
- grant_id  out  clog2(NUM_REQ)  index of the requester whose beat is in flight or last sent.
- busy  out  1  high in WAIT or SEND.

## Operation
- FSM states: IDLE, WAIT, SEND.
- IDLE:
  - The winner is the first requester with req_valid high, searching from (last_ptr+1) mod NUM_REQ upward with wrap.
  - req_ready[winner] is driven combinationally high in the same cycle; all other bits are 0.
  - On the transfer edge, latch req_data slice into out_data and winner into grant_id.
  - Latch cfg_delay into dly_cnt.
  - Next state: WAIT if cfg_delay != 0, else SEND.
  - With no req_valid, stay in IDLE and keep req_ready all-zero.
- WAIT:
  - Decrement dly_cnt each cycle.
  - When dly_cnt == 1, go to SEND on the next edge, giving exactly cfg_delay cycles in WAIT.
  - req_ready is all-zero.
- SEND:
  - out_valid is 1; out_data and grant_id are held stable until out_ready.
  - On out_valid && out_ready: last_ptr <= grant_id, out_valid <= 0, go to IDLE.
- req_ready is zero outside IDLE. Requesters may hold or drop req_valid freely; the arbiter never relies on persistence.
- cfg_delay is sampled only at accept. Changes during WAIT or SEND do not affect the beat in flight.
- A single active requester is granted on every IDLE pass; no lockout.

## Timing
- Reset values:
  - out_valid 0, out_data 0, grant_id 0, busy 0, req_ready 0 (combinational, IDLE with no request).
  - State IDLE, dly_cnt 0.
  - last_ptr NUM_REQ-1, so requester 0 wins first.
- Latency:
  - Accept edge at cycle T gives out_valid high at T+1+cfg_delay.
  - With out_ready tied high, the handshake completes in that cycle.
- Throughput: a beat completing at cycle S returns to IDLE at S+1, and the next accept can occur at S+1. Minimum period is 2+cfg_delay cycles per beat.
- Backpressure: out_ready low in SEND holds all outputs and the state indefinitely. No new accept occurs.
- Simultaneous events:
  - All requesters valid are served 0,1,2,...,NUM_REQ-1,0 (strict rotation).
  - out_ready is ignored outside SEND.
- Reset mid-operation: on the rst edge, all state returns to reset values. Any latched beat is discarded, not emitted. req_ready is 0 while rst is high.

## Configuration
- Macro OUT_ARB_STALL_CNT_EN.
- Defined:
  - Adds output stall_cnt, 16 bits.
  - Increments each cycle in SEND with out_ready low.
  - Saturates at 16'hFFFF; cleared only by rst.
- Undefined: the port and counter are absent. Functional behaviour is otherwise identical.

## Test plan
- Reset then idle: all req_valid 0 for 10 cycles. Required: out_valid 0, req_ready 0, busy 0 throughout.
- Single beat, cfg_delay=2, out_ready=1:
  - Stimulus: req_valid[2] with data 8'hA5 accepted at cycle T.
  - Required: out_valid for exactly one cycle at T+3, out_data 8'hA5, grant_id 2.
- Rotation, cfg_delay=0, out_ready=1:
  - Stimulus: all four requesters hold data 8'h10..8'h13.
  - Required: beats emerge 10,11,12,13,10 with grant_id 0,1,2,3,0, one beat every 2 cycles.
- Backpressure: out_ready low for 5 cycles in SEND. Required:
  - out_data and grant_id stable.
  - req_ready all-zero.
  - With OUT_ARB_STALL_CNT_EN, stall_cnt advances by 5.
- Reset mid-flight: rst asserted for one cycle during WAIT. Required:
  - out_valid never asserts for the discarded beat.
  - The next accept with all requesters valid goes to requester 0.
- cfg_delay change: cfg_delay changed from 3 to 0 during WAIT. Required: the current beat still appears 4 cycles after accept; the next beat uses delay 0.
